poly_add_wb: RTL and testbench

- Downstream write-back stage for the 24-bit dual-coefficient polynomial adder.
- Consumes the adder's packed 48-bit result stream: two coefficients mod q per word, a valid flag, and an end-of-stream pulse coincident with the last word.
- Generates sequential write address, write enable and data for the destination polynomial RAM.
- Counts words, checks stream length and coefficient range, reports done/error to the controlling FSM.

---
 rtl/poly_add_wb_if.sv | 24 ++
 rtl/poly_add_wb.sv | 83 ++++++++
 tb/tb_poly_add_wb.sv | 135 +++++++++++++
 3 files changed

// File: rtl/poly_add_wb_if.sv
// poly_add_wb_if: result-stream input, RAM write port and status of the write-back stage
interface poly_add_wb_if #(parameter int ADDR_W = 8);
  logic start;
  logic [ADDR_W-1:0] base_addr;
  logic in_flag;
  logic in_last;
  logic [47:0] din;
  logic we;
  logic [ADDR_W-1:0] waddr;
  logic [47:0] wdata;
  logic busy;
  logic done;
  logic err;
  logic [1:0] err_code;
  logic [ADDR_W:0] word_cnt;
  modport master (
    output start, base_addr, in_flag, in_last, din,
    input we, waddr, wdata, busy, done, err, err_code, word_cnt
  );
  modport slave (
    input start, base_addr, in_flag, in_last, din,
    output we, waddr, wdata, busy, done, err, err_code, word_cnt
  );
endinterface

// File: rtl/poly_add_wb.sv
// poly_add_wb: writes the adder's packed coefficient stream to RAM, checks length and range
module poly_add_wb #(
  parameter logic [23:0] Q = 24'd16515073,
  parameter int N_WORDS = 256,
  parameter int ADDR_W = 8
) (
  input logic clk,
  input logic rst,
  poly_add_wb_if.slave bus
);
  typedef enum logic [1:0] {IDLE, ARMED, WRITE, DONE} state_t;
  localparam logic [ADDR_W:0] N = (ADDR_W+1)'(N_WORDS);
  localparam logic [ADDR_W:0] CNT_MAX = '1;
  state_t state, nxt;
  logic [ADDR_W-1:0] base, waddr;
  logic [ADDR_W:0] cnt, cnt_inc;
  logic [47:0] wdata;
  logic [1:0] code;
  logic we, done, err, active, acc, bad;
  assign active = state == ARMED || state == WRITE;
  assign acc = active && bus.in_flag && !bus.start;
  assign bad = bus.din[47:24] >= Q || bus.din[23:0] >= Q;
  assign cnt_inc = cnt == CNT_MAX ? CNT_MAX : cnt + 1'b1;
  always_comb begin
    nxt = bus.start ? ARMED
        : !active ? IDLE
        : bus.in_flag ? (bus.in_last ? DONE : WRITE)
        : state == WRITE ? IDLE : ARMED;
  end
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else state <= nxt;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      base <= '0;
      cnt <= '0;
      we <= 1'b0;
      waddr <= '0;
      wdata <= '0;
      done <= 1'b0;
      err <= 1'b0;
      code <= 2'b00;
    end else begin
      we <= acc && cnt < N;
      done <= 1'b0;
      if (acc) begin
        waddr <= base + cnt[ADDR_W-1:0];
        wdata <= bus.din;
      end
      if (bus.start) begin
        base <= bus.base_addr;
        cnt <= '0;
        err <= 1'b0;
        code <= 2'b00;
      end else if (acc) begin
        cnt <= cnt_inc;
        if (bad) begin
          err <= 1'b1;
          code <= 2'b11;
        end else if (bus.in_last && code != 2'b11) begin
          // final word: judge length using the count including this word
          if (cnt_inc == N) done <= 1'b1;
          else begin
            err <= 1'b1;
            code <= cnt_inc < N ? 2'b01 : 2'b10;
          end
        end
      end else if (state == WRITE && !bus.in_flag) begin
        err <= 1'b1;
        code <= code == 2'b11 ? 2'b11 : 2'b01;
      end
    end
  end
  assign bus.we = we;
  assign bus.waddr = waddr;
  assign bus.wdata = wdata;
  assign bus.busy = active;
  assign bus.done = done;
  assign bus.err = err;
  assign bus.err_code = code;
  assign bus.word_cnt = cnt;
endmodule

// File: tb/tb_poly_add_wb.sv
// tb_poly_add_wb: directed streams with a write scoreboard for poly_add_wb
module tb_poly_add_wb;
  logic clk = 1'b0;
  logic rst;
  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int exp_wr = 0;
  int done_cnt = 0;
  int exp_done = 0;
  int idx = 0;
  logic [7:0] base = 8'h00;
  logic [55:0] q[$];
  localparam logic [23:0] Q = 24'd16515073;
  poly_add_wb_if #(.ADDR_W(8)) bus ();
  poly_add_wb #(.Q(Q), .N_WORDS(256), .ADDR_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk) begin
    if (bus.done === 1'b1) done_cnt++;
    if (bus.we === 1'b1) begin
      wr_cnt++;
      if (q.size() == 0) chk("unexpected_write", 64'(q.size()), 64'd1);
      else chk("write", {8'h0, bus.waddr, bus.wdata}, {8'h0, q.pop_front()});
    end
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic word(input logic [47:0] d, input logic last, input bit acc);
    bus.in_flag = 1'b1;
    bus.in_last = last;
    bus.din = d;
    if (acc) begin
      if (idx < 256) begin
        q.push_back({base + idx[7:0], d});
        exp_wr++;
      end
      idx++;
    end
    tick();
  endtask
  task automatic begin_stream(input logic [7:0] b);
    bus.start = 1'b1;
    bus.base_addr = b;
    bus.in_flag = 1'b1;
    bus.in_last = 1'b1;
    bus.din = 48'hABCDEF_123456;
    tick();
    bus.start = 1'b0;
    base = b;
    idx = 0;
  endtask
  task automatic idle(input int n);
    bus.in_flag = 1'b0;
    bus.in_last = 1'b0;
    repeat (n) tick();
  endtask
  function automatic logic [47:0] pat(input int i);
    return {24'(i), 24'(i + 1)};
  endfunction
  task automatic end_check(input string tag, input logic e, input logic [1:0] c, input int wc);
    chk({tag, "_queue_empty"}, 64'(q.size()), 64'd0);
    chk({tag, "_writes"}, 64'(wr_cnt), 64'(exp_wr));
    chk({tag, "_done"}, 64'(done_cnt), 64'(exp_done));
    chk({tag, "_err"}, {61'h0, bus.err, bus.err_code}, {61'h0, e, c});
    chk({tag, "_word_cnt"}, 64'(bus.word_cnt), 64'(wc));
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
  endtask
  initial begin
    rst = 1'b1;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.in_flag = 1'b0;
    bus.in_last = 1'b0;
    bus.din = '0;
    repeat (3) tick();
    chk("reset_outputs", {bus.we, bus.waddr, bus.wdata, bus.busy, bus.done, bus.err, bus.err_code, bus.word_cnt},
        64'h0);
    rst = 1'b0;
    idle(2);
    word(pat(7), 1'b1, 1'b0);
    idle(2);
    chk("idle_ignores_flag", 64'(wr_cnt), 64'd0);
    begin_stream(8'h10);
    for (int i = 0; i < 256; i++) word(pat(i), i == 255, 1'b1);
    exp_done++;
    idle(3);
    end_check("normal", 1'b0, 2'b00, 256);
    begin_stream(8'h30);
    for (int i = 0; i < 100; i++) word(pat(i + 1000), 1'b0, 1'b1);
    idle(3);
    end_check("short", 1'b1, 2'b01, 100);
    begin_stream(8'hF0);
    for (int i = 0; i < 258; i++) word(pat(i + 2000), i == 257, 1'b1);
    idle(3);
    end_check("long", 1'b1, 2'b10, 258);
    begin_stream(8'h40);
    for (int i = 0; i < 256; i++) begin
      word(i == 5 ? {Q, 24'd0} : pat(i + 3000), i == 255, 1'b1);
      if (i == 5) chk("range_err_immediate", {62'h0, bus.err, bus.err_code[0]}, 64'h3);
      if (i == 5) chk("range_code", 64'(bus.err_code), 64'd3);
    end
    idle(3);
    end_check("range", 1'b1, 2'b11, 256);
    begin_stream(8'h00);
    for (int i = 0; i < 40; i++) word(pat(i + 4000), 1'b0, 1'b1);
    rst = 1'b1;
    word(pat(9999), 1'b0, 1'b0);
    chk("midreset_outputs", {bus.we, bus.waddr, bus.wdata, bus.busy, bus.done, bus.err, bus.err_code, bus.word_cnt},
        64'h0);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) word(pat(i + 5000), i == 9, 1'b0);
    idle(3);
    end_check("midreset", 1'b0, 2'b00, 0);
    begin_stream(8'h20);
    for (int i = 0; i < 10; i++) word(pat(i + 6000), 1'b0, 1'b1);
    begin_stream(8'h80);
    word(pat(7000), 1'b0, 1'b1);
    chk("restart_word_cnt", 64'(bus.word_cnt), 64'd1);
    for (int i = 1; i < 256; i++) word(pat(i + 7000), i == 255, 1'b1);
    exp_done++;
    idle(3);
    end_check("restart", 1'b0, 2'b00, 256);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
